// File: rtl/otter_pkg.sv
// Shared Otter types: next-PC select encoding, fetch FSM states, reset vector.
package otter_pkg;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_PLUS4  = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Next-PC target select. Flags a redirect for every pcSource except PC+4 and
// the reserved codes 6/7, and clears bit 0 of the JALR target.
module next_pc_mux
    import otter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      pc_source,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] target,
    output logic            redirect
);

    always_comb begin
        target   = '0;
        redirect = 1'b0;
        case (pc_source)
            PC_JALR: begin
                target   = {jalr_target[XLEN-1:1], 1'b0};
                redirect = 1'b1;
            end
            PC_BRANCH: begin
                target   = branch_target;
                redirect = 1'b1;
            end
            PC_JAL: begin
                target   = jal_target;
                redirect = 1'b1;
            end
            PC_MTVEC: begin
                target   = mtvec;
                redirect = 1'b1;
            end
            PC_MEPC: begin
                target   = mepc;
                redirect = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC register and fetch sequencer for the pipelined Otter.
// Optional MISALIGN_CHECK_EN: park on redirect targets with bit 1 set and report them.
//
// state | meaning
// REQ   | request outstanding at pc; capture on ack
// HOLD  | IF/ID frozen by stall (or parked on a misaligned target)
// DROP  | waiting out the ack of an abandoned request
module pc_fetch_unit
    import otter_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      pcSource,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jal_target,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            stall_IF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir_IF,
    output logic [XLEN-1:0] pc_IF,
    output logic [XLEN-1:0] pc4_IF,
    output logic            valid_IF,
`ifdef MISALIGN_CHECK_EN
    output logic            instr_misaligned,
    output logic [XLEN-1:0] misaligned_addr,
`endif
    output logic            flush_IF,
    output logic            flush_ID
);

    localparam logic [XLEN-1:0] INC = XLEN'(4);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, pc_if_n, target;
    logic [31:0]     ir_n;
    logic            valid_n, redirect, bad_target, parked, parked_n;

    next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
        .pc_source     (pcSource),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .target        (target),
        .redirect      (redirect)
    );

`ifdef MISALIGN_CHECK_EN
    assign bad_target = redirect && target[1];
`else
    assign bad_target = 1'b0;
`endif

    assign imem_req  = (state == REQ) && !RST;
    assign imem_addr = pc;
    assign pc4_IF    = pc_IF + INC;
    assign flush_IF  = redirect && !RST;
    assign flush_ID  = redirect && !RST;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir_IF;
        pc_if_n  = pc_IF;
        valid_n  = valid_IF;
        parked_n = parked;
        case (state)
            REQ: begin
                if (redirect) begin
                    pc_n    = target;
                    valid_n = 1'b0;
                    state_n = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    ir_n    = imem_rdata;
                    pc_if_n = pc;
                    valid_n = 1'b1;
                    if (stall_IF) state_n = HOLD;
                    else          pc_n    = pc + INC;
                end else begin
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n     = target;
                    valid_n  = 1'b0;
                    parked_n = 1'b0;
                    state_n  = REQ;
                end else if (!stall_IF && !parked) begin
                    pc_n    = pc + INC;
                    valid_n = 1'b0;
                    state_n = REQ;
                end
            end
            DROP: begin
                valid_n = 1'b0;
                if (redirect) pc_n    = target;
                // a redirect landing on the stale ack still needs to leave DROP
                if (imem_ack) state_n = REQ;
            end
            default: state_n = REQ;
        endcase
        if (bad_target) begin
            state_n  = HOLD;
            parked_n = 1'b1;
            valid_n  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= REQ;
            pc       <= RESET_VEC;
            ir_IF    <= '0;
            pc_IF    <= RESET_VEC;
            valid_IF <= 1'b0;
            parked   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir_IF    <= ir_n;
            pc_IF    <= pc_if_n;
            valid_IF <= valid_n;
            parked   <= parked_n;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_misaligned <= 1'b0;
            misaligned_addr  <= '0;
        end else begin
            instr_misaligned <= bad_target;
            if (bad_target) misaligned_addr <= target;
        end
    end
`endif

endmodule
